// File: rtl/poker_pkg.sv
// Shared types for the poker table: command codes, card encoding, dealer FSM states.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package poker_pkg;

    localparam int DECK_SIZE = 52;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_CHECK    = 3'd1,
        CMD_CALL     = 3'd2,
        CMD_RAISE    = 3'd3,
        CMD_FOLD     = 3'd4,
        CMD_REQ_CARD = 3'd5,
        CMD_SHOW     = 3'd6,
        CMD_RSVD     = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        SUIT_CLUBS    = 2'd0,
        SUIT_DIAMONDS = 2'd1,
        SUIT_HEARTS   = 2'd2,
        SUIT_SPADES   = 2'd3
    } suit_e;

    typedef struct packed {
        suit_e      suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEAL      = 3'd1,
        ST_WAIT_CMD  = 3'd2,
        ST_ACK_DLY   = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_DROP = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // Deck index 0..51 -> {suit, rank}; suits are blocks of 13, ranks start at 2 (ace = 14).
    // Range compares instead of divide/modulo keep this a small mux.
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [5:0] base;
        logic [5:0] r;
        if (idx < 6'd13) begin
            c.suit = SUIT_CLUBS;
            base   = 6'd0;
        end else if (idx < 6'd26) begin
            c.suit = SUIT_DIAMONDS;
            base   = 6'd13;
        end else if (idx < 6'd39) begin
            c.suit = SUIT_HEARTS;
            base   = 6'd26;
        end else begin
            c.suit = SUIT_SPADES;
            base   = 6'd39;
        end
        r      = idx - base + 6'd2;
        c.rank = r[3:0];
        return c;
    endfunction

endpackage

// File: rtl/poker_deck.sv
// Permuted deck: holds the current deck position and the number of cards dealt this hand.
// Latency: card/empty are combinational from state; load/advance take effect on the next cycle.
// Backpressure: none; advance is ignored once all 52 cards are dealt.
module poker_deck
    import poker_pkg::*;
#(
    parameter int STRIDE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] seed,
    input  logic       advance,
    output card_t      card,
    output logic       empty
);

    localparam logic [6:0] STEP      = 7'(STRIDE);
    localparam logic [6:0] SIZE_W7   = 7'(DECK_SIZE);
    localparam logic [5:0] SIZE_W6   = 6'(DECK_SIZE);

    logic [5:0] pos;
    logic [5:0] dealt;
    logic [6:0] pos_sum;
    logic [6:0] pos_wrap;
    logic [5:0] pos_next;
    logic [5:0] seed_red;

    // Modular step through the deck plus seed folding into 0..51.
    always_comb begin
        pos_sum  = {1'b0, pos} + STEP;
        pos_wrap = pos_sum - SIZE_W7;
        pos_next = (pos_sum >= SIZE_W7) ? pos_wrap[5:0] : pos_sum[5:0];
        seed_red = (seed >= SIZE_W6) ? (seed - SIZE_W6) : seed;
    end

    // Position/dealt counters; a new hand reloads the start position and empties the discard count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos   <= '0;
            dealt <= '0;
        end else if (load) begin
            pos   <= seed_red;
            dealt <= '0;
        end else if (advance && !empty) begin
            pos   <= pos_next;
            dealt <= dealt + 6'd1;
        end
    end

    assign card  = idx_to_card(pos);
    assign empty = (dealt == SIZE_W6);

endmodule

// File: rtl/poker_dealer.sv
// Table-side dealer: starts hands, deals hole cards, acknowledges player commands.
// Latency: tbl_game_start 1 cycle after host_start; cr_ack ACK_LATENCY cycles after command acceptance.
// Backpressure: one command in flight; player must drop cr_cmdvld after the ack before the next is taken.
module poker_dealer
    import poker_pkg::*;
#(
    parameter int ACK_LATENCY = 2,
    parameter int STRIDE      = 7,
    parameter int HOLE_CARDS  = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_start,
    input  logic [5:0] seed,
    output logic       tbl_game_start,
    input  logic       cr_cmdvld,
    input  logic [2:0] cr_cmd,
    output logic       cr_ack,
    output logic       card_vld,
    output logic [5:0] card,
    output logic [2:0] last_cmd,
    output logic       cmd_err,
    output logic       timeout,
    output logic       game_over
);

    // Terminal values of the per-state cycle counter. DLY_LAST is unused when ACK_LATENCY is 1
    // because acceptance then goes straight to ACK.
    localparam logic [9:0] DEAL_LAST = 10'(HOLE_CARDS - 1);
    localparam logic [9:0] DLY_LAST  = 10'(ACK_LATENCY - 2);
    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);

    state_e     state;
    state_e     state_next;
    logic [9:0] cyc_in_state;
    cmd_e       cmd_q;
    cmd_e       last_cmd_q;
    logic       game_start_q;
    logic       timeout_q;
    logic       start_req;
    logic       idle_expired;
    card_t      deck_card;
    logic       deck_empty;

    assign start_req    = host_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign idle_expired = (state == ST_WAIT_CMD) && !cr_cmdvld && (cyc_in_state == TO_LAST);

    poker_deck #(
        .STRIDE (STRIDE)
    ) u_deck (
        .clk     (clk),
        .rst     (rst),
        .load    (start_req),
        .seed    (seed),
        .advance (card_vld),
        .card    (deck_card),
        .empty   (deck_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (host_start) state_next = ST_DEAL;
            ST_DEAL:          if (cyc_in_state == DEAL_LAST) state_next = ST_WAIT_CMD;
            ST_WAIT_CMD: begin
                if (cr_cmdvld)         state_next = (ACK_LATENCY == 1) ? ST_ACK : ST_ACK_DLY;
                else if (idle_expired) state_next = ST_DONE;
            end
            ST_ACK_DLY:       if (cyc_in_state == DLY_LAST) state_next = ST_ACK;
            ST_ACK:           state_next = (cmd_q == CMD_FOLD) ? ST_DONE : ST_WAIT_DROP;
            ST_WAIT_DROP:     if (!cr_cmdvld) state_next = ST_WAIT_CMD;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Per-state cycle counter (doubles as deal count, ack delay and idle timer), command capture,
    // and the registered one-cycle start/timeout pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_in_state <= '0;
            cmd_q        <= CMD_NOP;
            last_cmd_q   <= CMD_NOP;
            game_start_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cyc_in_state <= (state_next != state) ? '0 : cyc_in_state + 10'd1;
            game_start_q <= start_req;
            timeout_q    <= idle_expired;
            if ((state == ST_WAIT_CMD) && cr_cmdvld) cmd_q <= cmd_e'(cr_cmd);
            if (state == ST_ACK)   last_cmd_q <= cmd_q;
            else if (idle_expired) last_cmd_q <= CMD_FOLD;
        end
    end

    // Outputs decoded from state; last_cmd shows the captured command already in the ack cycle.
    always_comb begin
        cr_ack    = 1'b0;
        card_vld  = 1'b0;
        cmd_err   = 1'b0;
        game_over = 1'b0;
        last_cmd  = last_cmd_q;
        case (state)
            ST_DEAL: card_vld = !deck_empty;
            ST_ACK: begin
                cr_ack   = 1'b1;
                last_cmd = cmd_q;
                if (cmd_q == CMD_REQ_CARD) begin
                    card_vld = !deck_empty;
                    cmd_err  = deck_empty;
                end else if (cmd_q == CMD_RSVD) begin
                    cmd_err  = 1'b1;
                end
            end
            ST_DONE: game_over = 1'b1;
            default: ;
        endcase
        card = card_vld ? deck_card : 6'd0;
    end

    assign tbl_game_start = game_start_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_poker_dealer.sv
// Bench for poker_dealer: directed hands and commands, expected events queued, monitor compares.
// Latency: expected ack 2 cycles after acceptance, cards on deal cycles and ack cycles.
// Backpressure: player model holds cr_cmdvld until after the ack, then drops it for one cycle.
module tb_poker_dealer;

    localparam int ACK_LAT = 2;
    localparam int STRIDE  = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_start;
    logic [5:0] seed;
    logic       cr_cmdvld;
    logic [2:0] cr_cmd;
    logic       tbl_game_start;
    logic       cr_ack;
    logic       card_vld;
    logic [5:0] card;
    logic [2:0] last_cmd;
    logic       cmd_err;
    logic       timeout;
    logic       game_over;

    poker_dealer #(
        .ACK_LATENCY (ACK_LAT),
        .STRIDE      (STRIDE),
        .HOLE_CARDS  (2),
        .TIMEOUT     (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_start     (host_start),
        .seed           (seed),
        .tbl_game_start (tbl_game_start),
        .cr_cmdvld      (cr_cmdvld),
        .cr_cmd         (cr_cmd),
        .cr_ack         (cr_ack),
        .card_vld       (card_vld),
        .card           (card),
        .last_cmd       (last_cmd),
        .cmd_err        (cmd_err),
        .timeout        (timeout),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [5:0] card; } card_exp_t;
    typedef struct { int cyc; logic [2:0] cmd; logic err; } ack_exp_t;

    card_exp_t card_q[$];
    ack_exp_t  ack_q[$];
    int        start_q[$];
    int        to_q[$];

    int checks = 0;
    int errors = 0;
    bit seen[64];
    int distinct = 0;
    int m_pos = 0;
    int m_dealt = 0;

    function automatic logic [5:0] enc(input int idx);
        logic [1:0] s;
        logic [3:0] r;
        s = 2'(idx / 13);
        r = 4'(idx % 13 + 2);
        return {s, r};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: output seen with no expectation pending", name, cyc);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (tbl_game_start === 1'b1) begin
                if (start_q.size() == 0) unexpected("game_start");
                else check("game_start_cycle", cyc, start_q.pop_front());
                foreach (seen[i]) seen[i] = 1'b0;
                distinct = 0;
            end
            if (card_vld === 1'b1) begin
                if (card_q.size() == 0) unexpected("card_vld");
                else begin
                    card_exp_t e;
                    e = card_q.pop_front();
                    check("card_cycle", cyc, e.cyc);
                    check("card_value", card, e.card);
                end
                if (!seen[card]) begin
                    seen[card] = 1'b1;
                    distinct++;
                end
            end
            if (cr_ack === 1'b1) begin
                if (ack_q.size() == 0) unexpected("cr_ack");
                else begin
                    ack_exp_t a;
                    a = ack_q.pop_front();
                    check("ack_cycle", cyc, a.cyc);
                    check("ack_last_cmd", last_cmd, a.cmd);
                    check("ack_cmd_err", cmd_err, a.err);
                end
            end else if (cmd_err === 1'b1) begin
                unexpected("cmd_err_without_ack");
            end
            if (timeout === 1'b1) begin
                if (to_q.size() == 0) unexpected("timeout");
                else begin
                    check("timeout_cycle", cyc, to_q.pop_front());
                    check("timeout_last_cmd", last_cmd, 4);
                    check("timeout_game_over", game_over, 1);
                end
            end
        end
    endtask

    // Start a hand; c0/c1 are the hand-computed hole cards for this seed.
    task automatic start_hand(input logic [5:0] s, input logic [5:0] c0, input logic [5:0] c1);
        card_exp_t e;
        @(posedge clk); #1;
        host_start = 1'b1;
        seed       = s;
        start_q.push_back(cyc + 1);
        e.cyc = cyc + 1; e.card = c0; card_q.push_back(e);
        e.cyc = cyc + 2; e.card = c1; card_q.push_back(e);
        m_pos   = ((s >= 52) ? int'(s) - 52 : int'(s));
        m_pos   = (m_pos + 2 * STRIDE) % 52;
        m_dealt = 2;
        @(posedge clk); #1;
        host_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // One handshake: cr_cmdvld held for 'hold' cycles (>= ACK_LAT+1), cr_cmd disturbed after acceptance.
    task automatic cmd_hs(input logic [2:0] cmd, input int hold);
        ack_exp_t  a;
        card_exp_t e;
        int        acc;
        @(posedge clk); #1;
        cr_cmdvld = 1'b1;
        cr_cmd    = cmd;
        acc       = cyc;
        a.cyc = acc + ACK_LAT;
        a.cmd = cmd;
        a.err = (cmd == 3'd7) || (cmd == 3'd5 && m_dealt >= 52);
        ack_q.push_back(a);
        if (cmd == 3'd5 && m_dealt < 52) begin
            e.cyc  = acc + ACK_LAT;
            e.card = enc(m_pos);
            card_q.push_back(e);
            m_pos = (m_pos + STRIDE) % 52;
            m_dealt++;
        end
        @(posedge clk); #1;
        cr_cmd = cmd ^ 3'b011;
        repeat (hold - 1) @(posedge clk);
        #1;
        cr_cmdvld = 1'b0;
        cr_cmd    = 3'd0;
    endtask

    initial begin
        rst        = 1'b1;
        host_start = 1'b0;
        seed       = 6'd0;
        cr_cmdvld  = 1'b0;
        cr_cmd     = 3'd0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tbl_game_start, cr_ack, card_vld, card, last_cmd, cmd_err, timeout, game_over}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Hand 1: seed 0 -> idx 0 (0x02), idx 7 (0x09)
        start_hand(6'd0, 6'h02, 6'h09);
        cmd_hs(3'd2, 10);                       // CALL held 10 cycles: one ack only
        for (int i = 0; i < 50; i++) cmd_hs(3'd5, 3);
        @(negedge clk);
        check("distinct_cards", distinct, 52);
        cmd_hs(3'd5, 3);                        // deck empty -> cmd_err, no card
        cmd_hs(3'd7, 3);                        // reserved
        cmd_hs(3'd1, 3);
        cmd_hs(3'd3, 4);
        cmd_hs(3'd6, 3);
        cmd_hs(3'd0, 3);
        cmd_hs(3'd4, 3);                        // FOLD -> DONE
        @(negedge clk);
        check("fold_game_over", game_over, 1);

        // Hand 2: seed 60 reduces to 8 -> idx 8 (0x0A), idx 15 (0x14)
        start_hand(6'd60, 6'h0A, 6'h14);
        @(negedge clk);
        check("deal_clears_game_over", game_over, 0);
        @(posedge clk); #1;                     // host_start ignored outside IDLE/DONE
        host_start = 1'b1;
        seed       = 6'd0;
        @(posedge clk); #1;
        host_start = 1'b0;
        cmd_hs(3'd5, 3);                        // idx 22 -> 0x1B, proves no reload
        cmd_hs(3'd4, 3);

        // Hand 3: seed 5 -> idx 5 (0x07), idx 12 (0x0E); then idle until auto-fold
        start_hand(6'd5, 6'h07, 6'h0E);
        to_q.push_back(cyc + 256);
        repeat (262) @(posedge clk);
        @(negedge clk);
        check("timeout_game_over_level", game_over, 1);
        check("timeout_last_cmd_level", last_cmd, 4);

        // Hand 4: seed 52 -> idx 0, idx 7; reset during the ack delay drops the ack
        start_hand(6'd52, 6'h02, 6'h09);
        @(posedge clk); #1;
        cr_cmdvld = 1'b1;
        cr_cmd    = 3'd1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        cr_cmdvld = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", {tbl_game_start, cr_ack, card_vld, card, last_cmd, cmd_err, timeout, game_over}, 0);
        repeat (4) @(posedge clk);

        // Hand 5 after reset: seed 13 -> idx 13 (0x12), idx 20 (0x19)
        start_hand(6'd13, 6'h12, 6'h19);
        cmd_hs(3'd6, 3);
        cmd_hs(3'd4, 3);

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pending_cards", card_q.size(), 0);
        check("pending_acks", ack_q.size(), 0);
        check("pending_starts", start_q.size(), 0);
        check("pending_timeouts", to_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poker_dealer.md
Name: poker_dealer

Overview:
Table-side dealer that sits at the far end of the player command interface. It starts a hand, deals hole cards from a permuted 52-card deck, and accepts the player's cr_cmdvld/cr_cmd requests, answering each with a single-cycle cr_ack. It is the counterpart that the poker_player block is tested against, and it also serves as the table model in the lab environment.

Parameters:
ACK_LATENCY, 2, cycles from the command-acceptance cycle to the cr_ack cycle; legal range 1..15.
STRIDE, 7, deck permutation step; must be coprime to 52.
HOLE_CARDS, 2, cards dealt automatically per hand; legal range 1..4.
TIMEOUT, 255, idle cycles in WAIT_CMD before an auto-fold; legal range 1..1023.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
host_start  in  1  request to begin a hand
seed  in  6  deck start position; values 52..63 are reduced by subtracting 52
tbl_game_start  out  1  one-cycle pulse marking the start of a hand
cr_cmdvld  in  1  player command valid
cr_cmd  in  3  player command code
cr_ack  out  1  one-cycle acknowledge
card_vld  out  1  card valid strobe
card  out  6  card value as {suit[1:0], rank[3:0]}
last_cmd  out  3  most recently acknowledged command
cmd_err  out  1  one-cycle error flag (reserved code or empty deck)
timeout  out  1  one-cycle auto-fold flag
game_over  out  1  level; high while in DONE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; state IDLE; pos=0; dealt=0; idle timer=0. Reset wins over every other event. An ack or card that is pending when reset asserts is dropped.
- Card encoding:
  - Deck index i in 0..51 maps to suit=i/13 (0 clubs, 1 diamonds, 2 hearts, 3 spades) and rank=i%13+2 (ace=14).
  - pos advances by pos+STRIDE, with 52 subtracted when the sum is 52 or more.
  - dealt counts 0..52. No card repeats within a hand.
- Commands: 0 NOP, 1 CHECK, 2 CALL, 3 RAISE, 4 FOLD, 5 REQ_CARD, 6 SHOW, 7 reserved.
- IDLE:
  - host_start=1 loads pos=reduced seed and clears dealt.
  - tbl_game_start pulses high on the next cycle, and the state moves to DEAL.
- DEAL:
  - Runs HOLE_CARDS consecutive cycles. Each cycle drives card_vld=1 and card=enc(pos), advances pos, and increments dealt.
  - Then moves to WAIT_CMD with the idle timer cleared.
- WAIT_CMD:
  - cr_cmdvld=1 accepts the command: cr_cmd is captured, the timer is cleared, and the state moves to ACK_DLY.
  - Otherwise the timer increments. When it reaches TIMEOUT, timeout pulses, last_cmd=FOLD, no ack is issued, and the state moves to DONE.
- ACK_DLY: waits so that cr_ack is asserted exactly ACK_LATENCY cycles after the acceptance cycle. Changes on cr_cmd during this wait are ignored.
- ACK (single cycle):
  - cr_ack=1 and last_cmd=captured command.
  - REQ_CARD with dealt<52: card_vld=1 in the same cycle as the ack, then pos and dealt advance.
  - REQ_CARD with dealt=52: cmd_err=1, no card.
  - Code 7: cmd_err=1.
  - FOLD: next state is DONE. All other commands go to WAIT_DROP.
- WAIT_DROP:
  - Stays here while cr_cmdvld=1; commands are not accepted.
  - cr_cmdvld=0 moves to WAIT_CMD. The earliest next acceptance is the cycle after that.
- DONE:
  - game_over=1.
  - host_start behaves exactly as in IDLE.
- host_start is ignored in every state other than IDLE and DONE.

Decomposition:
- Package poker_pkg holds:
  - the cmd_e enum (3-bit)
  - suit_e
  - the card_t packed struct {suit, rank}
  - DECK_SIZE=52
  - the function idx_to_card
- One sub-module, poker_deck: owns pos and dealt, takes load/seed/advance inputs, and outputs card and empty. The FSM stays in poker_dealer.

Test Plan:
1. Reset, then host_start with seed=0 and STRIDE=7 -> tbl_game_start pulse; card_vld on 2 consecutive cycles with card=0x02 then 0x09; then WAIT_CMD.
2. CALL presented in WAIT_CMD and held for 10 cycles -> exactly one cr_ack, 2 cycles after acceptance; last_cmd=2; no re-ack until cr_cmdvld drops.
3. 50 REQ_CARD handshakes after the deal -> 50 cards, all 52 dealt cards distinct. The 51st REQ_CARD -> cr_ack with cmd_err=1 and no card_vld.
4. No command for 255 cycles after the deal -> timeout pulse, last_cmd=4, game_over=1, cr_ack never asserted.
5. FOLD -> cr_ack, then game_over=1. host_start with seed=60 -> first card is index 8 (0x0A).
6. rst pulsed during ACK_DLY -> no cr_ack; all outputs 0 on the cycle after rst; host_start is accepted afterwards.
